// File: rtl/ram_banked_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg : shared definitions for the banked scratch RAM.
//   ram_state_t   : controller state (CLEAR = zero-fill running, READY = normal)
//   bsel_w()      : bank-select field width for a given bank count
//   DEF_DATA_W    : default word width
//   DEF_BANK_AW   : default address bits per bank
// ---------------------------------------------------------------------------
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_state_t;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_BANK_AW = 3;

   // A single bank needs no select field at all.
   function automatic int bsel_w(input int nbanks);
      return (nbanks <= 1) ? 0 : $clog2(nbanks);
   endfunction

endpackage

// File: rtl/ram_banked_if.sv
// ---------------------------------------------------------------------------
// ram_banked_if : access bus of the banked RAM.
//   ADDR   : word address (bank field above word field)
//   DIN    : write data
//   RI     : write strobe
//   RD     : read request
//   DOUT   : read data, latency 1
//   DVALID : one-cycle pulse, DOUT updated this cycle
//   BUSY   : zero-clear running, RI/RD ignored
// master drives the requests, slave (the RAM) drives the responses.
// ---------------------------------------------------------------------------
interface ram_banked_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] DIN;
   logic              RI;
   logic              RD;
   logic [DATA_W-1:0] DOUT;
   logic              DVALID;
   logic              BUSY;

   modport master (output ADDR, DIN, RI, RD, input DOUT, DVALID, BUSY);
   modport slave  (input ADDR, DIN, RI, RD, output DOUT, DVALID, BUSY);
endinterface

// File: rtl/ram_banked_bank.sv
// ---------------------------------------------------------------------------
// ram_bank : one synchronous single-port bank of 2^BANK_AW words.
//   CLK : clock          EN : bank enable       WE : write enable
//   A   : word address   DI : write data        DO : registered read data
// DO only changes on an enabled read (EN & ~WE); it holds otherwise.
// ---------------------------------------------------------------------------
module ram_bank #(
   parameter int DATA_W  = 8,
   parameter int BANK_AW = 3
) (
   input  logic               CLK,
   input  logic               EN,
   input  logic               WE,
   input  logic [BANK_AW-1:0] A,
   input  logic [DATA_W-1:0]  DI,
   output logic [DATA_W-1:0]  DO
);

   logic [DATA_W-1:0] mem [2**BANK_AW];

   always_ff @(posedge CLK) begin
      if (EN) begin
         if (WE) mem[A] <= DI;
         else    DO     <= mem[A];
      end
   end

endmodule

// File: rtl/ram_banked.sv
// ---------------------------------------------------------------------------
// ram_banked : NBANKS x 2^BANK_AW x DATA_W synchronous RAM.
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset (array contents untouched)
//   bus   : ram_banked_if.slave (ADDR, DIN, RI, RD -> DOUT, DVALID, BUSY)
// Read latency is one cycle. A simultaneous read/write returns the new data.
// With CLEAR_ON_RESET=1 every word is zeroed after reset, one word index per
// cycle across all banks in parallel, while BUSY is high.
// ---------------------------------------------------------------------------
module ram_banked
   import ram_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int BANK_AW        = DEF_BANK_AW,
   parameter int NBANKS         = 2,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic         CLK,
   input  logic         RESET,
   ram_banked_if.slave  bus
);

   localparam int BSEL_W   = bsel_w(NBANKS);
   localparam int BSEL_EFF = (BSEL_W > 0) ? BSEL_W : 1;
   localparam int ADDR_W   = BANK_AW + BSEL_W;
   localparam logic [BANK_AW-1:0] PTR_LAST = BANK_AW'((2**BANK_AW) - 1);

   ram_state_t         state_q;
   logic [BANK_AW-1:0] ptr_q;
   logic               busy_q;
   logic               dvalid_q;
   logic               zero_q;      // DOUT forced to 0 until the first read
   logic               byp_q;       // last read was a write-through
   logic [BSEL_EFF-1:0] bsel_q;     // bank of the last read
   logic [DATA_W-1:0]  byp_data_q;

   logic [BSEL_EFF-1:0] bank_sel;
   logic [BANK_AW-1:0]  word_addr;
   logic [BANK_AW-1:0]  bank_a;
   logic [DATA_W-1:0]   bank_di;
   logic                bank_we;
   logic                ready;
   logic                access;
   logic [NBANKS-1:0]   bank_en;
   logic [DATA_W-1:0]   bank_do [NBANKS];

   generate
      if (BSEL_W > 0) begin : g_sel
         assign bank_sel = bus.ADDR[ADDR_W-1:BANK_AW];
      end else begin : g_nosel
         assign bank_sel = '0;
      end
   endgenerate

   assign word_addr = bus.ADDR[BANK_AW-1:0];
   assign ready     = (state_q == READY);
   assign access    = ready & (bus.RI | bus.RD);

   // CLEAR drives every bank with a zero write at the sweep pointer.
   assign bank_we = ~ready | bus.RI;
   assign bank_a  = ready ? word_addr : ptr_q;
   assign bank_di = ready ? bus.DIN : '0;

   generate
      for (genvar g = 0; g < NBANKS; g++) begin : g_bank
         assign bank_en[g] = ~RESET & (~ready | (access & (bank_sel == BSEL_EFF'(g))));

         ram_bank #(.DATA_W(DATA_W), .BANK_AW(BANK_AW)) u_bank (
            .CLK (CLK),
            .EN  (bank_en[g]),
            .WE  (bank_we),
            .A   (bank_a),
            .DI  (bank_di),
            .DO  (bank_do[g])
         );
      end
   endgenerate

   // Control: clear sequencer and read-response flags.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         busy_q   <= (CLEAR_ON_RESET != 0);
         ptr_q    <= '0;
         dvalid_q <= 1'b0;
         zero_q   <= 1'b1;
         byp_q    <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               dvalid_q <= 1'b0;
               ptr_q    <= ptr_q + 1'b1;
               if (ptr_q == PTR_LAST) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            READY: begin
               dvalid_q <= bus.RD;
               if (bus.RD) begin
                  zero_q <= 1'b0;
                  byp_q  <= bus.RI;
               end
            end
            default: state_q <= READY;
         endcase
      end
   end

   // Data side of the read response; qualified by the control flags above.
   always_ff @(posedge CLK) begin
      if (ready && bus.RD) begin
         bsel_q     <= bank_sel;
         byp_data_q <= bus.DIN;
      end
   end

   // Mux uses the registered bank so the data always matches the read address.
   assign bus.DOUT   = zero_q ? '0 : (byp_q ? byp_data_q : bank_do[bsel_q]);
   assign bus.DVALID = dvalid_q;
   assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_ram_banked.sv
// ---------------------------------------------------------------------------
// tb_ram_banked : bench for ram_banked. Default instance (2 banks x 8 x 8 bit)
// gets a directed vector table, a full-address read sweep and random traffic
// checked against a word-array reference model; a second instance
// (4 banks x 4 x 16 bit) gets a short directed sequence.
// ---------------------------------------------------------------------------
module tb_ram_banked;

   logic clk = 1'b0;
   logic rst0, rst1;
   always #5 clk = ~clk;

   ram_banked_if #(.DATA_W(8),  .ADDR_W(4)) b0 ();
   ram_banked_if #(.DATA_W(16), .ADDR_W(4)) b1 ();

   ram_banked #(.DATA_W(8), .BANK_AW(3), .NBANKS(2), .CLEAR_ON_RESET(1)) u0 (
      .CLK(clk), .RESET(rst0), .bus(b0));
   ram_banked #(.DATA_W(16), .BANK_AW(2), .NBANKS(4), .CLEAR_ON_RESET(1)) u1 (
      .CLK(clk), .RESET(rst1), .bus(b1));

   int tests = 0;
   int fails = 0;

   // Reference model: plain word array plus a count of remaining clear cycles.
   logic [7:0] m_mem [16];
   int         m_busy = 0;
   logic [7:0] m_dout = 8'h00;
   logic       m_dv   = 1'b0;

   typedef struct {
      logic       rst;
      logic       ri;
      logic       rd;
      logic [3:0] addr;
      logic [7:0] din;
      logic [7:0] e_dout;
      logic       e_dv;
      logic       e_busy;
   } vec_t;

   vec_t vt [34];

   function automatic vec_t V(input logic rst, ri, rd, input logic [3:0] a,
                              input logic [7:0] d, input logic [7:0] ed,
                              input logic edv, ebusy);
      vec_t v;
      v.rst = rst; v.ri = ri; v.rd = rd; v.addr = a; v.din = d;
      v.e_dout = ed; v.e_dv = edv; v.e_busy = ebusy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_edge(input logic rst, ri, rd, input logic [3:0] a, input logic [7:0] d);
      int ptr;
      if (rst) begin
         m_busy = 8;
         m_dout = 8'h00;
         m_dv   = 1'b0;
      end else if (m_busy > 0) begin
         ptr = 8 - m_busy;
         m_mem[ptr]     = 8'h00;
         m_mem[8 + ptr] = 8'h00;
         m_busy--;
         m_dv = 1'b0;
      end else begin
         if (rd) m_dout = ri ? d : m_mem[a];
         m_dv = rd;
         if (ri) m_mem[a] = d;
      end
   endtask

   // One clock on instance 0. After the edge the address is scrambled so a
   // mux that looked at the live address would show the wrong bank.
   task automatic cyc0(input logic rst, ri, rd, input logic [3:0] a, input logic [7:0] d);
      rst0 = rst; b0.RI = ri; b0.RD = rd; b0.ADDR = a; b0.DIN = d;
      @(posedge clk);
      model_edge(rst, ri, rd, a, d);
      #1;
      b0.ADDR = ~a; b0.RI = 1'b0; b0.RD = 1'b0; b0.DIN = ~d; rst0 = 1'b0;
      #1;
      chk("model_dout",   32'(b0.DOUT),   32'(m_dout));
      chk("model_dvalid", 32'(b0.DVALID), 32'(m_dv));
      chk("model_busy",   32'(b0.BUSY),   32'(m_busy > 0));
   endtask

   task automatic cyc1(input logic rst, ri, rd, input logic [3:0] a, input logic [15:0] d,
                       input logic [15:0] ed, input logic edv, ebusy, input string nm);
      rst1 = rst; b1.RI = ri; b1.RD = rd; b1.ADDR = a; b1.DIN = d;
      @(posedge clk);
      #1;
      b1.ADDR = ~a; b1.RI = 1'b0; b1.RD = 1'b0; rst1 = 1'b0;
      #1;
      chk({nm, "_dout"},   32'(b1.DOUT),   32'(ed));
      chk({nm, "_dvalid"}, 32'(b1.DVALID), 32'(edv));
      chk({nm, "_busy"},   32'(b1.BUSY),   32'(ebusy));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

      // Reset x2, clear with ignored write/read to addr 2, then directed traffic.
      vt[0]  = V(1, 0, 0, 4'd0,  8'h00, 8'h00, 0, 1);
      vt[1]  = V(1, 0, 0, 4'd0,  8'h00, 8'h00, 0, 1);
      vt[2]  = V(0, 1, 1, 4'd2,  8'hFF, 8'h00, 0, 1);
      vt[3]  = V(0, 1, 0, 4'd2,  8'hFF, 8'h00, 0, 1);
      vt[4]  = V(0, 1, 0, 4'd2,  8'hFF, 8'h00, 0, 1);
      vt[5]  = V(0, 1, 1, 4'd2,  8'hFF, 8'h00, 0, 1);
      vt[6]  = V(0, 1, 0, 4'd2,  8'hFF, 8'h00, 0, 1);
      vt[7]  = V(0, 1, 0, 4'd2,  8'hFF, 8'h00, 0, 1);
      vt[8]  = V(0, 1, 0, 4'd2,  8'hFF, 8'h00, 0, 1);
      vt[9]  = V(0, 1, 1, 4'd2,  8'hFF, 8'h00, 0, 0);
      vt[10] = V(0, 0, 1, 4'd2,  8'h00, 8'h00, 1, 0);
      vt[11] = V(0, 1, 0, 4'd3,  8'hA5, 8'h00, 0, 0);
      vt[12] = V(0, 1, 0, 4'd11, 8'h5A, 8'h00, 0, 0);
      vt[13] = V(0, 0, 1, 4'd3,  8'h00, 8'hA5, 1, 0);
      vt[14] = V(0, 0, 1, 4'd11, 8'h00, 8'h5A, 1, 0);
      vt[15] = V(0, 0, 0, 4'd0,  8'h00, 8'h5A, 0, 0);
      vt[16] = V(0, 1, 0, 4'd6,  8'h11, 8'h5A, 0, 0);
      vt[17] = V(0, 1, 1, 4'd6,  8'h77, 8'h77, 1, 0);
      vt[18] = V(0, 0, 1, 4'd6,  8'h00, 8'h77, 1, 0);
      vt[19] = V(0, 0, 1, 4'd0,  8'h00, 8'h00, 1, 0);
      // Reset from READY, then reset again at the fifth BUSY cycle.
      vt[20] = V(1, 0, 0, 4'd0,  8'h00, 8'h00, 0, 1);
      for (int i = 21; i <= 24; i++) vt[i] = V(0, 0, 0, 4'd0, 8'h00, 8'h00, 0, 1);
      vt[25] = V(1, 0, 0, 4'd0,  8'h00, 8'h00, 0, 1);
      for (int i = 26; i <= 32; i++) vt[i] = V(0, 1, 1, 4'd3, 8'hA5, 8'h00, 0, 1);
      vt[33] = V(0, 0, 0, 4'd0,  8'h00, 8'h00, 0, 0);

      rst0 = 1'b1; rst1 = 1'b1;
      b0.ADDR = '0; b0.DIN = '0; b0.RI = 1'b0; b0.RD = 1'b0;
      b1.ADDR = '0; b1.DIN = '0; b1.RI = 1'b0; b1.RD = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 34; i++) begin
         cyc0(vt[i].rst, vt[i].ri, vt[i].rd, vt[i].addr, vt[i].din);
         chk($sformatf("vec%0d_dout", i),   32'(b0.DOUT),   32'(vt[i].e_dout));
         chk($sformatf("vec%0d_dvalid", i), 32'(b0.DVALID), 32'(vt[i].e_dv));
         chk($sformatf("vec%0d_busy", i),   32'(b0.BUSY),   32'(vt[i].e_busy));
      end

      // Whole array reads zero after the second full clear.
      for (int a = 0; a < 16; a++) begin
         cyc0(1'b0, 1'b0, 1'b1, 4'(a), 8'h00);
         chk($sformatf("sweep%0d_dout", a),   32'(b0.DOUT),   32'h0);
         chk($sformatf("sweep%0d_dvalid", a), 32'(b0.DVALID), 32'h1);
      end

      // Random traffic with occasional resets against the model.
      for (int n = 0; n < 600; n++) begin
         cyc0(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom),
              4'($urandom), 8'($urandom));
      end

      // Second instance: 4 banks of 4 words, 16-bit data.
      cyc1(1, 0, 0, 4'd0, 16'h0, 16'h0, 0, 1, "p_rst");
      cyc1(0, 0, 0, 4'd0, 16'h0, 16'h0, 0, 1, "p_clr1");
      cyc1(0, 0, 0, 4'd0, 16'h0, 16'h0, 0, 1, "p_clr2");
      cyc1(0, 0, 0, 4'd0, 16'h0, 16'h0, 0, 1, "p_clr3");
      cyc1(0, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, "p_clr4");
      cyc1(0, 1, 0, 4'd13, 16'h1234, 16'h0, 0, 0, "p_wr13");
      cyc1(0, 0, 1, 4'd13, 16'h0, 16'h1234, 1, 0, "p_rd13");
      cyc1(0, 0, 1, 4'd1,  16'h0, 16'h0000, 1, 0, "p_rd1");
      cyc1(0, 0, 1, 4'd13, 16'h0, 16'h1234, 1, 0, "p_rd13b");
      cyc1(0, 0, 1, 4'd9,  16'h0, 16'h0000, 1, 0, "p_rd9");
      cyc1(0, 0, 0, 4'd0,  16'h0, 16'h0000, 0, 0, "p_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_banked.md
Name: ram_banked

Overview:
- Parametrised banked synchronous RAM; the next generation of the 16x8 two-bank scratch RAM in the CPU datapath.
- NBANKS banks of 2^BANK_AW words, each DATA_W wide. The upper address bits select the bank.
- Adds four things:
  - a registered read path with a valid flag;
  - a registered bank select, so read data always matches the address that was read;
  - write-through on simultaneous read/write;
  - an optional post-reset zero-clear sequencer with a BUSY flag.

Parameters:
- DATA_W, 8, word width in bits.
- BANK_AW, 3, address bits per bank; words per bank = 2^BANK_AW.
- NBANKS, 2, bank count; power of two, >= 1.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents undefined, ready immediately.
- Derived: BSEL_W = clog2(NBANKS) (0 if NBANKS = 1); ADDR_W = BANK_AW + BSEL_W.

Ports:
- CLK     in   1       system clock, rising edge.
- RESET   in   1       synchronous, active-high reset.
- ADDR    in   ADDR_W  word address; [ADDR_W-1:BANK_AW] = bank, [BANK_AW-1:0] = word.
- DIN     in   DATA_W  write data.
- RI      in   1       write strobe (RAM In).
- RD      in   1       read request.
- DOUT    out  DATA_W  registered read data.
- DVALID  out  1       one-cycle pulse: DOUT updated this cycle.
- BUSY    out  1       clear in progress; RI/RD ignored.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high: RESET sampled high at a rising CLK edge.
- Reset values:
  - DOUT = 0, DVALID = 0, clear pointer = 0.
  - BUSY = CLEAR_ON_RESET.
  - State = CLEAR if CLEAR_ON_RESET, else READY.
  - Reset does not touch array contents.
- States: CLEAR, READY.
- CLEAR:
  - Each edge with RESET low writes 0 to word [ptr] in every bank in parallel, then ptr increments.
  - The edge that writes ptr = 2^BANK_AW-1 moves the state to READY and drives BUSY 0 (registered).
  - BUSY is therefore high for exactly 2^BANK_AW cycles after reset release.
  - RI and RD are ignored; DVALID stays 0; DOUT holds 0.
- READY, write (RI=1, RD=0): DIN is written to bank ADDR[bank], word ADDR[word] at the edge. DVALID = 0 next cycle; DOUT unchanged.
- READY, read (RD=1, RI=0):
  - Array read at the edge. Bank select and the bank word are registered together.
  - DOUT shows mem[ADDR] and DVALID = 1 in the next cycle (latency 1).
- READY, RI=1 and RD=1: write-through. Array written with DIN; next cycle DOUT = DIN, DVALID = 1. Never returns old data.
- READY, idle (RD=0): DVALID = 0; DOUT holds its last value.
- Bank enables: only the addressed bank is enabled in READY; all banks are enabled in CLEAR; no bank is enabled while RESET is high.
- Back-to-back reads at different banks on consecutive cycles: each DOUT reflects its own address. The mux uses the registered bank select, never the live ADDR.
- Reset during CLEAR: restarts at ptr = 0, full duration again.
- Reset in READY: DOUT = 0, DVALID = 0 next cycle, clear restarts (if enabled).
- Widths: the pointer is BANK_AW bits with no wrap past the last word. ADDR values are always in range (ADDR_W is exact).
- NBANKS = 1: no bank field; a single bank of depth 2^BANK_AW.

Decomposition:
- Package ram_pkg holds:
  - state enum ram_state_t {CLEAR, READY};
  - the clog2-based BSEL_W function;
  - the default DATA_W/BANK_AW constants.
- Sub-module ram_bank: one bank, parameters DATA_W and BANK_AW. Ports CLK, EN, WE, A, DI, DO; registered read on EN & ~WE.
- ram_banked instantiates NBANKS of these via generate, plus the clear FSM and output/bypass register.

Test Plan:
- Reset clear: CLEAR_ON_RESET=1, defaults. Assert RESET 2 cycles, release. Expect BUSY high exactly 8 cycles, then low. Read all 16 addresses: all DOUT = 0x00, each with DVALID 1 cycle after RD.
- Bank isolation: write 0xA5 to addr 3 and 0x5A to addr 11. Read 3 then 11 back-to-back. Expect DOUT = 0xA5 then 0x5A on consecutive cycles, DVALID high both.
- Write-through: addr 6 holds 0x11. Drive RI=1, RD=1, ADDR=6, DIN=0x77. Next cycle expect DOUT = 0x77, DVALID = 1. A later plain read of 6 returns 0x77.
- Busy gating: during CLEAR, drive RI=1, ADDR=2, DIN=0xFF. After BUSY falls, read 2: expect 0x00. DVALID stays 0 throughout CLEAR.
- Reset mid-clear: pulse RESET at BUSY cycle 5. Expect BUSY to stay high 8 full cycles after the second release; previously written 0xA5 at addr 3 reads 0x00.
- Parametrised: NBANKS=4, BANK_AW=2, DATA_W=16. Write 0x1234 to addr 13, read it back: DOUT = 0x1234. Addr 1 (same word index, bank 0) still reads 0x0000.
